lsu_memory_pipe: RTL and testbench

LSU_MEMORY_PIPE -- requirements
Module: lsu_memory_pipe

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_load_queue.sv | 89 ++++++++
 rtl/lsu_memory_pipe.sv | 144 ++++++++++++++
 tb/tb_lsu_memory_pipe.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared access-size encoding and load-queue entry layout for the LSU memory pipe.
// Revision 1.0
`default_nettype none

package lsu_pkg;

   typedef enum logic [1:0] {
      BYTE  = 2'd0,
      HALF  = 2'd1,
      WORD  = 2'd2,
      DWORD = 2'd3
   } size_e;

   // Field widths sized for the largest supported configuration (tag <= 8 bits, data <= 512 bits).
   localparam int LQ_TAG_W = 8;
   localparam int LQ_OFS_W = 6;

   typedef struct packed {
      logic [LQ_TAG_W-1:0] tag;
      size_e               size;
      logic                uns;
      logic [LQ_OFS_W-1:0] offset;
   } lq_meta_t;

   function automatic size_e clamp_size(input logic [1:0] size, input int max_log2);
      if (int'(size) > max_log2)
         return size_e'(max_log2[1:0]);
      return size_e'(size);
   endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_queue.sv
// lsu_load_queue -- in-order load queue; entries are filled by memory responses or forwarding, popped at the head.
// Revision 1.0
`default_nettype none

module lsu_load_queue
   import lsu_pkg::*;
#(
   parameter int BW_DATA  = 32,
   parameter int LQ_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enq,
   input  lq_meta_t           enq_meta,
   input  logic               enq_dv,
   input  logic [BW_DATA-1:0] enq_data,
   output logic               full,
   input  logic               fill,
   input  logic [BW_DATA-1:0] fill_data,
   output logic               fill_found,
   output lq_meta_t           fill_meta,
   output logic               head_valid,
   output lq_meta_t           head_meta,
   output logic [BW_DATA-1:0] head_data,
   input  logic               pop
);

   localparam int AW = $clog2(LQ_DEPTH);

   logic [AW:0]         wr_ptr;
   logic [AW:0]         rd_ptr;
   logic [AW:0]         count;
   logic [AW-1:0]       wr_idx;
   logic [AW-1:0]       rd_idx;
   logic [AW-1:0]       fill_ptr;
   logic [LQ_DEPTH-1:0] dv;
   lq_meta_t            meta_mem [LQ_DEPTH];
   logic [BW_DATA-1:0]  data_mem [LQ_DEPTH];

   assign wr_idx     = wr_ptr[AW-1:0];
   assign rd_idx     = rd_ptr[AW-1:0];
   assign count      = wr_ptr - rd_ptr;
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
   assign head_valid = (count != '0) && dv[rd_idx];
   assign head_meta  = meta_mem[rd_idx];
   assign head_data  = data_mem[rd_idx];
   assign fill_meta  = meta_mem[fill_ptr];

   // Fill pointer: oldest occupied entry still waiting for memory data (forwarded entries are skipped).
   always_comb begin
      fill_found = 1'b0;
      fill_ptr   = rd_idx;
      for (int i = LQ_DEPTH - 1; i >= 0; i--) begin
         if (((AW+1)'(i) < count) && !dv[rd_idx + AW'(i)]) begin
            fill_found = 1'b1;
            fill_ptr   = rd_idx + AW'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         dv     <= '0;
      end else begin
         if (enq) begin
            dv[wr_idx] <= enq_dv;
            wr_ptr     <= wr_ptr + 1'b1;
         end
         if (fill && fill_found)
            dv[fill_ptr] <= 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         meta_mem[wr_idx] <= enq_meta;
         data_mem[wr_idx] <= enq_data;
      end
      if (fill && fill_found)
         data_mem[fill_ptr] <= fill_data;
   end

endmodule

`default_nettype wire

// File: rtl/lsu_memory_pipe.sv
// lsu_memory_pipe -- issues loads/stores to data memory, extends load results and broadcasts them on the CDB in order.
// Revision 1.0
`default_nettype none

module lsu_memory_pipe
   import lsu_pkg::*;
#(
   parameter int BW_PROCESSOR_DATA = 32,
   parameter int BW_ADDRESS        = 32,
   parameter int BW_TAG            = 4,
   parameter int LQ_DEPTH          = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_lsrsv_valid,
   output logic                           i_lsrsv_ready,
   input  logic                           i_lsrsv_opcode,
   input  logic [1:0]                     i_lsrsv_size,
   input  logic                           i_lsrsv_unsigned,
   input  logic [BW_TAG-1:0]              i_lsrsv_tag,
   input  logic [BW_ADDRESS-1:0]          i_lsrsv_rwaddr,
   input  logic [BW_PROCESSOR_DATA-1:0]   i_lsrsv_wdata,
   input  logic                           i_lsrsv_load_forwarding_valid,
   input  logic [BW_PROCESSOR_DATA-1:0]   i_lsrsv_load_forwarding_data,
   output logic                           o_D_mem_valid,
   input  logic                           o_D_mem_ready,
   output logic                           o_D_mem_r0w1,
   output logic [BW_ADDRESS-1:0]          o_D_mem_rwaddr,
   output logic [BW_PROCESSOR_DATA-1:0]   o_D_mem_wdata,
   output logic [BW_PROCESSOR_DATA/8-1:0] o_D_mem_wstrb,
   input  logic                           i_D_mem_rvalid,
   input  logic [BW_PROCESSOR_DATA-1:0]   i_D_mem_rdata,
   output logic                           o_cdb_valid,
   input  logic                           o_cdb_ready,
   output logic [BW_TAG-1:0]              o_cdb_tag,
   output logic [BW_PROCESSOR_DATA-1:0]   o_cdb_data
);

   localparam int NB = BW_PROCESSOR_DATA / 8;
   localparam int OW = $clog2(NB);
   localparam int IW = $clog2(BW_PROCESSOR_DATA);

   logic                         alive;
   logic                         is_load, fwd_load, accept, req_load, lq_full;
   size_e                        esize;
   logic [OW-1:0]                offset;
   logic [NB-1:0]                strobe;
   logic [BW_PROCESSOR_DATA-1:0] rep_data;
   logic                         req_valid, req_r0w1;
   logic [BW_ADDRESS-1:0]        req_addr;
   logic [BW_PROCESSOR_DATA-1:0] req_wdata;
   logic [NB-1:0]                req_wstrb;
   lq_meta_t                     enq_meta, fill_meta, head_meta;
   logic                         fill_found, head_valid;
   logic [BW_PROCESSOR_DATA-1:0] shifted, fill_data, head_data;
   logic [IW-1:0]                msb_idx;

   assign is_load  = !i_lsrsv_opcode;
   assign fwd_load = is_load && i_lsrsv_load_forwarding_valid;
   assign i_lsrsv_ready = alive && (!is_load || !lq_full) && (fwd_load || !req_valid || o_D_mem_ready);
   assign accept   = i_lsrsv_valid && i_lsrsv_ready;
   assign req_load = accept && !fwd_load;
   assign esize    = clamp_size(i_lsrsv_size, OW);

   always_comb begin
      offset   = i_lsrsv_rwaddr[OW-1:0] & ~OW'((1 << int'(esize)) - 1);
      strobe   = ((NB'(1) << (1 << int'(esize))) - NB'(1)) << offset;
      rep_data = '0;
      for (int b = 0; b < NB; b++)
         rep_data[b*8 +: 8] = i_lsrsv_wdata[(b & ((1 << int'(esize)) - 1))*8 +: 8];
   end

   // Holds ready low for the first edge after reset release so every output is 0 during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) alive <= 1'b0;
      else        alive <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_valid <= 1'b0;
         req_r0w1  <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
         req_wstrb <= '0;
      end else if (req_load) begin
         req_valid <= 1'b1;
         req_r0w1  <= i_lsrsv_opcode;
         req_addr  <= {i_lsrsv_rwaddr[BW_ADDRESS-1:OW], OW'(0)};
         req_wdata <= i_lsrsv_opcode ? rep_data : '0;
         req_wstrb <= i_lsrsv_opcode ? strobe : '0;
      end else if (o_D_mem_ready) begin
         req_valid <= 1'b0;
      end
   end

   assign o_D_mem_valid  = req_valid;
   assign o_D_mem_r0w1   = req_r0w1;
   assign o_D_mem_rwaddr = req_addr;
   assign o_D_mem_wdata  = req_wdata;
   assign o_D_mem_wstrb  = req_wstrb;

   assign enq_meta = '{tag: LQ_TAG_W'(i_lsrsv_tag), size: esize, uns: i_lsrsv_unsigned,
                       offset: LQ_OFS_W'(offset)};

   // Response extraction: align the addressed bytes to bit 0, then sign/zero extend from the access width.
   always_comb begin
      shifted   = i_D_mem_rdata >> (int'(fill_meta.offset[OW-1:0]) * 8);
      msb_idx   = IW'((8 << int'(fill_meta.size)) - 1);
      fill_data = '0;
      for (int i = 0; i < BW_PROCESSOR_DATA; i++) begin
         if (i <= int'(msb_idx)) fill_data[i] = shifted[i];
         else                    fill_data[i] = !fill_meta.uns && shifted[msb_idx];
      end
   end

   lsu_load_queue #(
      .BW_DATA  (BW_PROCESSOR_DATA),
      .LQ_DEPTH (LQ_DEPTH)
   ) u_lq (
      .clk        (clk),
      .rst_n      (rst_n),
      .enq        (accept && is_load),
      .enq_meta   (enq_meta),
      .enq_dv     (fwd_load),
      .enq_data   (i_lsrsv_load_forwarding_data),
      .full       (lq_full),
      .fill       (i_D_mem_rvalid),
      .fill_data  (fill_data),
      .fill_found (fill_found),
      .fill_meta  (fill_meta),
      .head_valid (head_valid),
      .head_meta  (head_meta),
      .head_data  (head_data),
      .pop        (head_valid && o_cdb_ready)
   );

   assign o_cdb_valid = head_valid;
   assign o_cdb_tag   = head_valid ? BW_TAG'(head_meta.tag) : '0;
   assign o_cdb_data  = head_valid ? head_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_lsu_memory_pipe.sv
// tb_lsu_memory_pipe -- scoreboard bench: expected CDB results queued at acceptance, checked when broadcast.
`default_nettype none

module tb_lsu_memory_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_lsrsv_valid = 1'b0;
   logic        i_lsrsv_ready;
   logic        i_lsrsv_opcode = 1'b0;
   logic [1:0]  i_lsrsv_size = 2'd0;
   logic        i_lsrsv_unsigned = 1'b0;
   logic [3:0]  i_lsrsv_tag = 4'd0;
   logic [31:0] i_lsrsv_rwaddr = 32'd0;
   logic [31:0] i_lsrsv_wdata = 32'd0;
   logic        i_lsrsv_load_forwarding_valid = 1'b0;
   logic [31:0] i_lsrsv_load_forwarding_data = 32'd0;
   logic        o_D_mem_valid;
   logic        o_D_mem_ready = 1'b1;
   logic        o_D_mem_r0w1;
   logic [31:0] o_D_mem_rwaddr;
   logic [31:0] o_D_mem_wdata;
   logic [3:0]  o_D_mem_wstrb;
   logic        i_D_mem_rvalid = 1'b0;
   logic [31:0] i_D_mem_rdata = 32'd0;
   logic        o_cdb_valid;
   logic        o_cdb_ready = 1'b1;
   logic [3:0]  o_cdb_tag;
   logic [31:0] o_cdb_data;

   int          n_tests = 0;
   int          n_fail = 0;
   bit          resp_en = 1'b1;
   logic [35:0] sb[$];
   logic [31:0] rdata_q[$];
   logic [31:0] resp_q[$];

   always #5 clk = ~clk;

   lsu_memory_pipe #(
      .BW_PROCESSOR_DATA (32),
      .BW_ADDRESS        (32),
      .BW_TAG            (4),
      .LQ_DEPTH          (4)
   ) dut (
      .clk                           (clk),
      .rst_n                         (rst_n),
      .i_lsrsv_valid                 (i_lsrsv_valid),
      .i_lsrsv_ready                 (i_lsrsv_ready),
      .i_lsrsv_opcode                (i_lsrsv_opcode),
      .i_lsrsv_size                  (i_lsrsv_size),
      .i_lsrsv_unsigned              (i_lsrsv_unsigned),
      .i_lsrsv_tag                   (i_lsrsv_tag),
      .i_lsrsv_rwaddr                (i_lsrsv_rwaddr),
      .i_lsrsv_wdata                 (i_lsrsv_wdata),
      .i_lsrsv_load_forwarding_valid (i_lsrsv_load_forwarding_valid),
      .i_lsrsv_load_forwarding_data  (i_lsrsv_load_forwarding_data),
      .o_D_mem_valid                 (o_D_mem_valid),
      .o_D_mem_ready                 (o_D_mem_ready),
      .o_D_mem_r0w1                  (o_D_mem_r0w1),
      .o_D_mem_rwaddr                (o_D_mem_rwaddr),
      .o_D_mem_wdata                 (o_D_mem_wdata),
      .o_D_mem_wstrb                 (o_D_mem_wstrb),
      .i_D_mem_rvalid                (i_D_mem_rvalid),
      .i_D_mem_rdata                 (i_D_mem_rdata),
      .o_cdb_valid                   (o_cdb_valid),
      .o_cdb_ready                   (o_cdb_ready),
      .o_cdb_tag                     (o_cdb_tag),
      .o_cdb_data                    (o_cdb_data)
   );

   task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Memory model: read handshakes queue their data; responses return one per cycle when enabled.
   always @(negedge clk) begin
      if (o_D_mem_valid && o_D_mem_ready && !o_D_mem_r0w1) begin
         if (rdata_q.size() > 0) resp_q.push_back(rdata_q.pop_front());
         else check_eq("mem_unexpected_read", 1, 0);
      end
   end

   always @(posedge clk) begin
      #1;
      if (resp_en && resp_q.size() > 0) begin
         i_D_mem_rvalid = 1'b1;
         i_D_mem_rdata  = resp_q.pop_front();
      end else begin
         i_D_mem_rvalid = 1'b0;
         i_D_mem_rdata  = 32'd0;
      end
   end

   always @(negedge clk) begin
      if (rst_n && o_cdb_valid && o_cdb_ready) begin
         if (sb.size() == 0) begin
            check_eq("cdb_spurious", {60'd0, o_cdb_tag}, 64'hFFFF);
         end else begin
            logic [35:0] e;
            e = sb.pop_front();
            check_eq("cdb_tag", {60'd0, o_cdb_tag}, {60'd0, e[35:32]});
            check_eq("cdb_data", {32'd0, o_cdb_data}, {32'd0, e[31:0]});
         end
      end
   end

   task automatic send_req(input bit st, input logic [1:0] sz, input bit uns, input logic [3:0] tag,
                           input logic [31:0] addr, input logic [31:0] wd, input bit fwd,
                           input logic [31:0] fd, input logic [31:0] rdata, input logic [31:0] exp);
      bit done = 1'b0;
      i_lsrsv_opcode = st;  i_lsrsv_size = sz;  i_lsrsv_unsigned = uns;  i_lsrsv_tag = tag;
      i_lsrsv_rwaddr = addr;  i_lsrsv_wdata = wd;
      i_lsrsv_load_forwarding_valid = fwd;  i_lsrsv_load_forwarding_data = fd;
      i_lsrsv_valid = 1'b1;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         done = i_lsrsv_ready;
         @(posedge clk);
         #1;
      end
      i_lsrsv_valid = 1'b0;
      if (!done) check_eq("accept_timeout", 0, 1);
      else if (!st) begin
         sb.push_back({tag, exp});
         if (!fwd) rdata_q.push_back(rdata);
      end
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 300 && sb.size() != 0; c++) @(negedge clk);
      check_eq("drain", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_store(input string name, input logic [31:0] addr, input logic [3:0] strb,
                              input logic [31:0] data);
      @(negedge clk);
      check_eq({name, "_valid"}, {63'd0, o_D_mem_valid}, 1);
      check_eq({name, "_r0w1"},  {63'd0, o_D_mem_r0w1}, 1);
      check_eq({name, "_addr"},  {32'd0, o_D_mem_rwaddr}, {32'd0, addr});
      check_eq({name, "_wstrb"}, {60'd0, o_D_mem_wstrb}, {60'd0, strb});
      check_eq({name, "_wdata"}, {32'd0, o_D_mem_wdata}, {32'd0, data});
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_mem_valid", {63'd0, o_D_mem_valid}, 0);
      check_eq("rst_cdb_valid", {63'd0, o_cdb_valid}, 0);
      check_eq("rst_ready", {63'd0, i_lsrsv_ready}, 0);
      check_eq("rst_outputs", {o_D_mem_rwaddr, o_D_mem_wdata} | {28'd0, o_D_mem_wstrb, o_cdb_data},
               0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Stores: byte, half, and dword clamped to full width.
      send_req(1, 2'd0, 0, 4'd0, 32'h103, 32'hAB, 0, 0, 0, 0);
      check_store("st_byte", 32'h100, 4'b1000, 32'hABABABAB);
      send_req(1, 2'd1, 0, 4'd0, 32'h206, 32'h1234, 0, 0, 0, 0);
      check_store("st_half", 32'h204, 4'b1100, 32'h12341234);
      send_req(1, 2'd3, 0, 4'd0, 32'h10, 32'hCAFEF00D, 0, 0, 0, 0);
      check_store("st_dword", 32'h10, 4'b1111, 32'hCAFEF00D);

      // Loads: signed/unsigned half, signed byte, clamped dword.
      send_req(0, 2'd1, 0, 4'd5, 32'h202, 0, 0, 0, 32'h80010000, 32'hFFFF8001);
      @(negedge clk);
      check_eq("ld_req_addr", {32'd0, o_D_mem_rwaddr}, 64'h200);
      check_eq("ld_req_r0w1", {63'd0, o_D_mem_r0w1}, 0);
      check_eq("ld_req_wstrb", {60'd0, o_D_mem_wstrb}, 0);
      @(posedge clk);
      #1;
      send_req(0, 2'd1, 1, 4'd6, 32'h202, 0, 0, 0, 32'h80010000, 32'h00008001);
      send_req(0, 2'd0, 0, 4'd7, 32'h301, 0, 0, 0, 32'h1122F344, 32'hFFFFFFF3);
      send_req(0, 2'd3, 1, 4'd4, 32'h404, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF);
      wait_drain();

      // Ordering: a forwarded load waits behind an unfilled memory load.
      resp_en = 1'b0;
      send_req(0, 2'd2, 0, 4'd1, 32'h600, 0, 0, 0, 32'h11110000, 32'h11110000);
      send_req(0, 2'd2, 0, 4'd2, 32'h604, 0, 1, 32'h55, 0, 32'h55);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("order_blocked", {63'd0, o_cdb_valid}, 0);
      resp_en = 1'b1;
      wait_drain();

      // CDB backpressure fills the LQ; loads blocked, stores still accepted.
      o_cdb_ready = 1'b0;
      send_req(0, 2'd2, 0, 4'd8, 32'h700, 0, 1, 32'h88, 0, 32'h88);
      @(negedge clk);
      check_eq("fwd_latency_valid", {63'd0, o_cdb_valid}, 1);
      check_eq("fwd_latency_tag", {60'd0, o_cdb_tag}, 8);
      @(posedge clk);
      #1;
      send_req(0, 2'd2, 0, 4'd9, 32'h704, 0, 0, 0, 32'h99, 32'h99);
      send_req(0, 2'd2, 0, 4'd10, 32'h708, 0, 1, 32'hAA, 0, 32'hAA);
      send_req(0, 2'd2, 0, 4'd11, 32'h70C, 0, 0, 0, 32'hBB, 32'hBB);
      repeat (3) @(posedge clk);
      #1;
      i_lsrsv_opcode = 1'b0;
      i_lsrsv_load_forwarding_valid = 1'b0;
      @(negedge clk);
      check_eq("full_load_ready", {63'd0, i_lsrsv_ready}, 0);
      i_lsrsv_load_forwarding_valid = 1'b1;
      #1;
      check_eq("full_fwd_ready", {63'd0, i_lsrsv_ready}, 0);
      i_lsrsv_opcode = 1'b1;
      #1;
      check_eq("full_store_ready", {63'd0, i_lsrsv_ready}, 1);
      @(posedge clk);
      #1;
      send_req(1, 2'd2, 0, 4'd0, 32'h20, 32'h1, 0, 0, 0, 0);
      o_cdb_ready = 1'b1;
      wait_drain();

      // Memory stall: request held stable, non-forwarded requests refused.
      o_D_mem_ready = 1'b0;
      send_req(0, 2'd2, 0, 4'd3, 32'h500, 0, 0, 0, 32'hA5, 32'hA5);
      i_lsrsv_opcode = 1'b0;
      i_lsrsv_load_forwarding_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_eq("stall_valid", {63'd0, o_D_mem_valid}, 1);
         check_eq("stall_addr", {32'd0, o_D_mem_rwaddr}, 64'h500);
         check_eq("stall_ready", {63'd0, i_lsrsv_ready}, 0);
         @(posedge clk);
         #1;
      end
      i_lsrsv_load_forwarding_valid = 1'b1;
      @(negedge clk);
      check_eq("stall_fwd_ready", {63'd0, i_lsrsv_ready}, 1);
      @(posedge clk);
      #1;
      o_D_mem_ready = 1'b1;
      wait_drain();

      // Reset mid-flight: pending loads discarded, late responses ignored.
      resp_en = 1'b0;
      send_req(0, 2'd2, 0, 4'd12, 32'h800, 0, 0, 0, 32'hC0, 32'hC0);
      send_req(0, 2'd2, 0, 4'd13, 32'h804, 0, 0, 0, 32'hD0, 32'hD0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb.delete();
      @(negedge clk);
      check_eq("midrst_mem_valid", {63'd0, o_D_mem_valid}, 0);
      check_eq("midrst_cdb_valid", {63'd0, o_cdb_valid}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      resp_en = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      check_eq("midrst_resp_done", resp_q.size(), 0);
      check_eq("midrst_no_cdb", {63'd0, o_cdb_valid}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
